// File: rtl/_muxn_arb_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
// Provides the width of out_sel/ptr and a modulo-m wrap helper.
package constants;
    localparam int WORD_LENGTH    = 32;
    localparam int MUX_MAX_INPUTS = 16;

    // Width of an index into m inputs, never less than one bit.
    function automatic int sel_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Reduce v modulo m for 0 <= v < 2*m.
    function automatic int wrap_idx(input int v, input int m);
        return (v >= m) ? v - m : v;
    endfunction
endpackage

// File: rtl/_muxn_arb_prio_enc.sv
// m-bit priority encoder: lowest set request bit wins.
// Produces a one-hot grant and the binary index of the winner.
module _prio_enc
    import constants::*;
#(
    parameter int m = 4
) (
    input  logic [m-1:0]              req,
    output logic [m-1:0]              grant,
    output logic [sel_width(m)-1:0]   idx
);
    localparam int SW = sel_width(m);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < m; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                idx      = SW'(i);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/_muxn_arb.sv
// N-input arbitrating multiplexer with valid/ready handshakes and a one-entry output register.
// Define MUXN_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module _muxn_arb
    import constants::*;
#(
    parameter int n = WORD_LENGTH,
    parameter int m = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [m-1:0]              in_valid,
    output logic [m-1:0]              in_ready,
    input  logic [m-1:0][n-1:0]       in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [n-1:0]              out,
    output logic [sel_width(m)-1:0]   out_sel
);
    localparam int SW = sel_width(m);

    logic          out_valid_reg;
    logic [n-1:0]  out_reg;
    logic [SW-1:0] out_sel_reg;

    logic          accept;
    logic          any_req;
    logic [m-1:0]  grant;
    logic [SW-1:0] gidx;

    assign accept  = !out_valid_reg || out_ready;
    assign any_req = |in_valid;

`ifdef MUXN_ARB_ROUND_ROBIN_EN
    logic [SW-1:0] ptr_reg;
    logic [m-1:0]  rot_req;
    logic [m-1:0]  rot_grant;
    logic [SW-1:0] rot_idx;

    // Rotate requests right by ptr so the encoder's bit 0 is the current favourite.
    genvar gi;
    generate
        for (gi = 0; gi < m; gi++) begin : g_rot
            assign rot_req[gi] = in_valid[wrap_idx(gi + int'(ptr_reg), m)];
        end
    endgenerate

    _prio_enc #(.m(m)) u_prio_enc (
        .req   (rot_req),
        .grant (rot_grant),
        .idx   (rot_idx)
    );

    assign gidx  = SW'(wrap_idx(int'(rot_idx) + int'(ptr_reg), m));
    assign grant = any_req ? (m'(1) << gidx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (accept && any_req) begin
            ptr_reg <= SW'(wrap_idx(int'(gidx) + 1, m));
        end
    end
`else
    _prio_enc #(.m(m)) u_prio_enc (
        .req   (in_valid),
        .grant (grant),
        .idx   (gidx)
    );
`endif

    // Gated by rst_n so no handshake completes while the stage is held in reset.
    assign in_ready = grant & {m{accept && rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_sel_reg   <= '0;
        end else if (accept) begin
            if (any_req) begin
                out_valid_reg <= 1'b1;
                out_reg       <= in[gidx];
                out_sel_reg   <= gidx;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign out_sel   = out_sel_reg;
endmodule
